rv_pipe_buffer: RTL and testbench

RV_PIPE_BUFFER -- requirements
Module: rv_pipe_buffer

---
 rtl/rv_pipe_buffer.sv | 89 ++++++++
 tb/tb_rv_pipe_buffer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rv_pipe_buffer.sv
// rv_pipe_buffer: small ready/valid FIFO placed between two pipeline stages.
// Entries are registered; a pushed payload is visible downstream one cycle later,
// and ready/valid never depend combinationally on the opposite side of the buffer.
module rv_pipe_buffer #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned DEPTH = 2,
   parameter logic [DATA_W-1:0] FLUSH_FILL =
      DATA_W'({8{32'hAAAAAAAA}} & ((256'd1 << ((DATA_W / 32) * 32)) - 256'd1)),
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic              up_valid_i,
   input  logic [DATA_W-1:0] up_data_i,
   output logic              up_ready_o,
   output logic              dn_valid_o,
   output logic [DATA_W-1:0] dn_data_o,
   input  logic              dn_ready_i,
   output logic [CNT_W-1:0]  count_o
);

   // Pointer width is at least one bit so DEPTH = 1 still has a legal index.
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic              push;
   logic              pop;

   // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
   endfunction

   // Handshake terms come only from registered occupancy and flush, so a full
   // buffer refuses the push even when the head is being popped the same cycle.
   assign up_ready_o = (count < FULL_CNT) && !flush_i;
   assign dn_valid_o = (count != '0);
   assign dn_data_o  = mem[rd_ptr];
   assign count_o    = count;
   assign push       = up_valid_i && up_ready_o;
   assign pop        = dn_valid_o && dn_ready_i && !flush_i;

   // Pointer and occupancy tracking; flush wins over any push or pop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   // Entry storage; flush overwrites every slot so the empty head shows a known pattern.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (flush_i) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= FLUSH_FILL;
         end
      end else if (push) begin
         mem[wr_ptr] <= up_data_i;
      end
   end

endmodule

// File: tb/tb_rv_pipe_buffer.sv
// Testbench for rv_pipe_buffer: three instances (DEPTH 1, 2, 3) checked against a
// queue-based reference model of the buffer's ready/valid behaviour.
module tb_rv_pipe_buffer;

   localparam logic [63:0] FILL = 64'hAAAAAAAA_AAAAAAAA;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        up_valid;
   logic        dn_ready;
   logic [63:0] up_data;
   int          cur;

   logic        v1, v2, v3, r1, r2, r3;
   logic        rdy1, rdy2, rdy3, val1, val2, val3;
   logic [63:0] dat1, dat2, dat3;
   logic        cnt1;
   logic [1:0]  cnt2, cnt3;

   // Reference model state
   logic [63:0] mq[$];
   logic        empty_known;
   logic [63:0] empty_val;
   int          checks = 0;
   int          fails = 0;

   // Free-running clock
   always #5 clk = ~clk;

   // Only the instance under test sees handshake activity
   assign v1 = up_valid && (cur == 1);
   assign v2 = up_valid && (cur == 2);
   assign v3 = up_valid && (cur == 3);
   assign r1 = dn_ready && (cur == 1);
   assign r2 = dn_ready && (cur == 2);
   assign r3 = dn_ready && (cur == 3);

   rv_pipe_buffer #(.DATA_W(64), .DEPTH(1)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .up_valid_i(v1), .up_data_i(up_data),
      .up_ready_o(rdy1), .dn_valid_o(val1), .dn_data_o(dat1), .dn_ready_i(r1), .count_o(cnt1));

   rv_pipe_buffer #(.DATA_W(64), .DEPTH(2)) dut2 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .up_valid_i(v2), .up_data_i(up_data),
      .up_ready_o(rdy2), .dn_valid_o(val2), .dn_data_o(dat2), .dn_ready_i(r2), .count_o(cnt2));

   rv_pipe_buffer #(.DATA_W(64), .DEPTH(3)) dut3 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .up_valid_i(v3), .up_data_i(up_data),
      .up_ready_o(rdy3), .dn_valid_o(val3), .dn_data_o(dat3), .dn_ready_i(r3), .count_o(cnt3));

   // Single comparison point: counts every evaluation and every failure
   task automatic doCheck(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Compare the selected instance's outputs with the model's current view
   task automatic checkOutput(input string tag);
      logic [63:0] o_cnt, o_val, o_rdy, o_dat;
      case (cur)
         1: begin o_cnt = 64'(cnt1); o_val = 64'(val1); o_rdy = 64'(rdy1); o_dat = dat1; end
         2: begin o_cnt = 64'(cnt2); o_val = 64'(val2); o_rdy = 64'(rdy2); o_dat = dat2; end
         default: begin o_cnt = 64'(cnt3); o_val = 64'(val3); o_rdy = 64'(rdy3); o_dat = dat3; end
      endcase
      doCheck({tag, "/count"}, o_cnt, 64'(mq.size()));
      doCheck({tag, "/dn_valid"}, o_val, 64'(mq.size() != 0));
      doCheck({tag, "/up_ready"}, o_rdy, 64'((mq.size() < cur) && !flush));
      if (mq.size() != 0) begin
         doCheck({tag, "/dn_data"}, o_dat, mq[0]);
      end else if (empty_known) begin
         doCheck({tag, "/empty_data"}, o_dat, empty_val);
      end
   endtask

   // One clock cycle: drive inputs, check pre-edge outputs, advance the model at the edge
   task automatic applyStimulus(input logic v, input logic [63:0] d, input logic r,
                                input logic f, input string tag, output logic pushed);
      logic do_push, do_pop;
      @(negedge clk);
      up_valid = v;
      up_data  = d;
      dn_ready = r;
      flush    = f;
      #1;
      checkOutput(tag);
      do_push = v && (mq.size() < cur) && !f;
      do_pop  = (mq.size() != 0) && r && !f;
      @(posedge clk);
      if (f) begin
         mq.delete();
         empty_known = 1'b1;
         empty_val   = FILL;
      end else begin
         if (do_pop) void'(mq.pop_front());
         if (do_push) begin
            mq.push_back(d);
            empty_known = 1'b0;
         end
      end
      pushed = do_push;
   endtask

   // Assert reset between clock edges and check the outputs clear without a clock edge
   task automatic applyReset(input string tag);
      @(negedge clk);
      up_valid = 1'b0;
      dn_ready = 1'b0;
      flush    = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      mq.delete();
      empty_known = 1'b1;
      empty_val   = 64'h0;
      checkOutput(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   // Directed and randomized sequence
   initial begin
      logic        p;
      logic [63:0] pay [10];
      int          idx;
      int          budget;

      rst_n = 1'b0; flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b0; up_data = '0;
      empty_known = 1'b1; empty_val = '0;
      cur = 2;
      applyReset("rst_d2");

      $display("[TB] DEPTH=2 fill");
      applyStimulus(1'b1, 64'h11, 1'b0, 1'b0, "push11", p);
      applyStimulus(1'b1, 64'h22, 1'b0, 1'b0, "push22", p);
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, "full", p);

      $display("[TB] DEPTH=2 drain while offering 0x33");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 64'h33, 1'b1, 1'b0, "drain33", p);
      end
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, "after33", p);

      $display("[TB] DEPTH=2 flush with push and pop");
      applyStimulus(1'b1, 64'h77, 1'b1, 1'b1, "flush_a", p);
      applyStimulus(1'b1, 64'h88, 1'b1, 1'b1, "flush_b", p);
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, "postflush", p);
      doCheck("flush_fill", dat2, FILL);

      $display("[TB] DEPTH=2 asynchronous reset when full");
      applyStimulus(1'b1, 64'h01, 1'b0, 1'b0, "fill01", p);
      applyStimulus(1'b1, 64'h02, 1'b0, 1'b0, "fill02", p);
      applyReset("midrst");
      applyStimulus(1'b1, 64'h44, 1'b0, 1'b0, "push44", p);
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, "show44", p);
      doCheck("data44", dat2, 64'h44);

      $display("[TB] DEPTH=3 random stream");
      cur = 3;
      applyReset("rst_d3");
      for (int i = 0; i < 10; i++) pay[i] = {$urandom, $urandom};
      idx = 0;
      budget = 0;
      while ((idx < 10 || mq.size() != 0) && budget < 400) begin
         applyStimulus((idx < 10) && ($urandom_range(0, 1) == 1), (idx < 10) ? pay[idx] : 64'h0,
                       $urandom_range(0, 2) != 0, 1'b0, "rand", p);
         if (p) idx++;
         budget++;
      end
      doCheck("rand_all_pushed", 64'(idx), 64'd10);
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, "rand_end", p);

      $display("[TB] DEPTH=1 stage register");
      cur = 1;
      applyReset("rst_d1");
      applyStimulus(1'b1, 64'h55, 1'b0, 1'b0, "push55", p);
      applyStimulus(1'b1, 64'h66, 1'b1, 1'b0, "refuse66", p);
      applyStimulus(1'b1, 64'h66, 1'b0, 1'b0, "take66", p);
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, "show66", p);
      doCheck("data66", dat1, 64'h66);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
